// File: rtl/tsv_share_arbiter.sv
// rtl/tsv_share_arbiter.sv - round-robin time-sharing of one TSV bundle among NREQ requesters
//
// Ports:
//   clk1        in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [NREQ]     requester i has a word
//   req_data    in   [NREQ*DW]  requester i word at [i*DW +: DW]
//   req_ready   out  [NREQ]     one-hot grant, combinational, only in IDLE
//   tsv_valid   out             word present on the TSVs
//   tsv_id      out  [IDW]      source requester of the word on the TSVs
//   tsv_data    out  [DW]       payload on the TSVs
//   tsv_ack     in              far layer accepted the word
//   busy        out             high while sending or settling
//   err_timeout out             sticky: a transfer was aborted unacknowledged
module tsv_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2,
  parameter int TURN = 1,
  parameter int TMO  = 15
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               tsv_valid,
  output logic [IDW-1:0]     tsv_id,
  output logic [DW-1:0]      tsv_data,
  input  logic               tsv_ack,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_TURN} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TMO - 1);
  localparam logic [3:0] TURN_LAST = 4'((TURN > 0) ? TURN - 1 : 0);
  // With no settle gap a finished transfer returns straight to IDLE.
  localparam state_t     DONE_ST   = (TURN > 0) ? S_TURN : S_IDLE;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [7:0]     tmo_cnt;
  logic [3:0]     turn_cnt;
  logic           any_valid;
  logic [IDW-1:0] win_idx;
  logic [DW-1:0]  win_data;
  logic           abort;

  // Round-robin search starting at rr_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    int j;
    j         = 0;
    any_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_valid && req_valid[j]) begin
        any_valid = 1'b1;
        win_idx   = IDW'(j);
      end
    end
  end

  assign win_data = req_data[win_idx*DW +: DW];

  // Gated by rst_n so no grant is advertised while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == S_IDLE && any_valid) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      S_IDLE: if (any_valid) state_nxt = S_SEND;
      S_SEND: begin
        // Ack on the expiry cycle wins over the abort.
        if (tsv_ack) begin
          state_nxt = DONE_ST;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = DONE_ST;
          abort     = 1'b1;
        end
      end
      S_TURN: if (turn_cnt == TURN_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      turn_cnt    <= '0;
      tsv_valid   <= 1'b0;
      tsv_id      <= '0;
      tsv_data    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      tsv_valid <= (state_nxt == S_SEND);
      busy      <= (state_nxt != S_IDLE);
      if (abort) err_timeout <= 1'b1;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            tsv_id   <= win_idx;
            tsv_data <= win_data;
            rr_ptr   <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            tmo_cnt  <= '0;
          end
        end
        S_SEND: begin
          tmo_cnt  <= tmo_cnt + 8'd1;
          turn_cnt <= '0;
        end
        S_TURN:  turn_cnt <= turn_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tsv_share_arbiter.sv
// tb/tb_tsv_share_arbiter.sv - self-checking bench for tsv_share_arbiter
module tb_tsv_share_arbiter;

  localparam int TURN = 1;
  localparam int TMO  = 15;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tsv_valid;
  logic [1:0]  tsv_id;
  logic [7:0]  tsv_data;
  logic        tsv_ack;
  logic        busy;
  logic        err_timeout;

  logic [3:0]  v0;
  logic [31:0] d0;
  logic [3:0]  rdy0;
  logic        tv0;
  logic [1:0]  tid0;
  logic [7:0]  tdat0;
  logic        ack0;
  logic        busy0;
  logic        err0;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_rr   = 0;
  logic m_err = 1'b0;
  int m0_rr  = 0;

  always #5 clk1 = ~clk1;

  tsv_share_arbiter #(.NREQ(4), .DW(8), .IDW(2), .TURN(TURN), .TMO(TMO)) dut (
    .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tsv_valid(tsv_valid), .tsv_id(tsv_id), .tsv_data(tsv_data),
    .tsv_ack(tsv_ack), .busy(busy), .err_timeout(err_timeout)
  );

  tsv_share_arbiter #(.NREQ(4), .DW(8), .IDW(2), .TURN(0), .TMO(TMO)) dut0 (
    .clk1(clk1), .rst_n(rst_n), .req_valid(v0), .req_data(d0),
    .req_ready(rdy0), .tsv_valid(tv0), .tsv_id(tid0), .tsv_data(tdat0),
    .tsv_ack(ack0), .busy(busy0), .err_timeout(err0)
  );

  // One whole transfer on dut, starting just after a negedge in IDLE.
  // ack_at: SEND cycle index (0-based) on which ack is raised; >= TMO means never.
  task automatic xfer(input logic [3:0] v, input logic [31:0] d, input int ack_at, output int gid);
    int w;
    logic [3:0] exp_rdy;
    logic [7:0] wd;
    req_valid = v; req_data = d; tsv_ack = 1'b0;
    #1;
    w = -1;
    for (int k = 0; k < 4; k++) if (w < 0 && v[(m_rr + k) % 4]) w = (m_rr + k) % 4;
    exp_rdy = (w < 0) ? 4'b0000 : 4'(1 << w);
    gid = w;
    n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL grant: got %b want %b", req_ready, exp_rdy); end
    if (w < 0) begin
      @(negedge clk1); req_valid = 4'b0; #1;
      n_cmp++; if (tsv_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL no_req: got valid=%b busy=%b want 0 0", tsv_valid, busy); end
      return;
    end
    wd = d[w*8 +: 8];
    m_rr = (w + 1) % 4;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk1);
      req_valid = 4'($urandom);
      #1;
      n_cmp++;
      if (tsv_valid !== 1'b1 || tsv_id !== 2'(w) || tsv_data !== wd || busy !== 1'b1 ||
          req_ready !== 4'b0 || err_timeout !== m_err) begin
        n_fail++;
        $display("FAIL send c%0d: got v=%b id=%0d d=%h busy=%b rdy=%b err=%b want 1 %0d %h 1 0000 %b",
                 c, tsv_valid, tsv_id, tsv_data, busy, req_ready, err_timeout, w, wd, m_err);
      end
      tsv_ack = (c == ack_at);
      if (c == ack_at) break;
    end
    if (ack_at >= TMO) m_err = 1'b1;
    for (int t = 0; t < TURN; t++) begin
      @(negedge clk1);
      tsv_ack = 1'($urandom);
      #1;
      n_cmp++;
      if (tsv_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0 || err_timeout !== m_err ||
          tsv_id !== 2'(w) || tsv_data !== wd) begin
        n_fail++;
        $display("FAIL turn: got v=%b busy=%b rdy=%b err=%b id=%0d d=%h want 0 1 0000 %b %0d %h",
                 tsv_valid, busy, req_ready, err_timeout, tsv_id, tsv_data, m_err, w, wd);
      end
    end
    @(negedge clk1);
    req_valid = 4'b0; tsv_ack = 1'b0;
    #1;
    n_cmp++;
    if (tsv_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || err_timeout !== m_err) begin
      n_fail++;
      $display("FAIL idle_after: got v=%b busy=%b rdy=%b err=%b want 0 0 0000 %b",
               tsv_valid, busy, req_ready, err_timeout, m_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; req_data = 32'h0; tsv_ack = 1'b0;
    v0 = 4'b0; d0 = 32'h0; ack0 = 1'b0;
    repeat (3) @(negedge clk1);
    #1;
    n_cmp++;
    if (tsv_valid !== 1'b0 || tsv_id !== 2'd0 || tsv_data !== 8'h00 || req_ready !== 4'b0 ||
        busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got v=%b id=%0d d=%h rdy=%b busy=%b err=%b want all 0",
               tsv_valid, tsv_id, tsv_data, req_ready, busy, err_timeout);
    end
    @(negedge clk1);
    rst_n = 1'b1; req_valid = 4'b0;
    m_rr = 0; m_err = 1'b0; m0_rr = 0;
  endtask

  // All four valid, ack held high: one word every 1 + 1 + TURN cycles.
  task automatic test_round_robin();
    logic [7:0] wd;
    req_valid = 4'b1111; req_data = $urandom; tsv_ack = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk1); #1;
      n_cmp++;
      if (tsv_valid !== (i % 3 == 1) || busy !== (i % 3 != 0)) begin
        n_fail++;
        $display("FAIL rr_pattern i%0d: got v=%b busy=%b want %b %b", i, tsv_valid, busy, (i % 3 == 1), (i % 3 != 0));
      end
      if (i % 3 == 1) begin
        wd = req_data[m_rr*8 +: 8];
        n_cmp++;
        if (tsv_id !== 2'(m_rr) || tsv_data !== wd) begin
          n_fail++;
          $display("FAIL rr_id i%0d: got id=%0d d=%h want %0d %h", i, tsv_id, tsv_data, m_rr, wd);
        end
        m_rr = (m_rr + 1) % 4;
      end
    end
    req_valid = 4'b0; tsv_ack = 1'b0;
  endtask

  task automatic test_single();
    int gid;
    xfer(4'b0100, {8'h11, 8'hA5, 8'h22, 8'h33}, 3, gid);
    n_cmp++; if (gid !== 2) begin n_fail++; $display("FAIL single_id: got %0d want 2", gid); end
  endtask

  task automatic test_wrap_skip();
    int gid;
    int exp_ids[4] = '{3, 0, 3, 0};
    logic [3:0] vs[4] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      xfer(vs[i], $urandom, 0, gid);
      n_cmp++; if (gid !== exp_ids[i]) begin n_fail++; $display("FAIL wrap_%0d: got %0d want %0d", i, gid, exp_ids[i]); end
    end
  endtask

  task automatic test_ack_on_expiry();
    int gid;
    xfer(4'b0010, $urandom, TMO - 1, gid);
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL ack_expiry: got err=%b want 0", err_timeout); end
  endtask

  task automatic test_timeout();
    int gid;
    xfer(4'b0001, $urandom, TMO + 3, gid);
    n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err_timeout); end
    xfer(4'b1000, $urandom, 1, gid);
    n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_mid_send();
    int gid;
    req_valid = 4'b1111; req_data = $urandom;
    @(negedge clk1); #1;
    n_cmp++; if (tsv_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_send: got %b want 1", tsv_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tsv_valid !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b rdy=%b busy=%b err=%b want 0 0000 0 0", tsv_valid, req_ready, busy, err_timeout);
    end
    m_rr = 0; m_err = 1'b0; m0_rr = 0;
    @(negedge clk1);
    rst_n = 1'b1;
    xfer(4'b1111, $urandom, 0, gid);
    n_cmp++; if (gid !== 0) begin n_fail++; $display("FAIL reset_first_grant: got %0d want 0", gid); end
  endtask

  task automatic test_random();
    int gid;
    int ack_at;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 4) == 0) ack_at = $urandom_range(TMO - 2, TMO + 4);
      else ack_at = $urandom_range(0, 3);
      xfer(4'($urandom_range(0, 15)), $urandom, ack_at, gid);
      if ($urandom_range(0, 1) == 1) @(negedge clk1);
    end
  endtask

  // TURN=0 instance: valid toggles 1,0,1,0; ack pulses while idle are ignored.
  task automatic test_turn0();
    logic [1:0] last_id;
    int w;
    v0 = 4'b1111; d0 = $urandom; ack0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk1); #1;
      n_cmp++;
      if (tv0 !== (i % 2 == 1) || busy0 !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL t0_pattern i%0d: got v=%b busy=%b want %b", i, tv0, busy0, (i % 2 == 1));
      end
      if (i % 2 == 1) begin
        n_cmp++;
        if (tid0 !== 2'(m0_rr) || tdat0 !== d0[m0_rr*8 +: 8]) begin
          n_fail++;
          $display("FAIL t0_id i%0d: got id=%0d d=%h want %0d %h", i, tid0, tdat0, m0_rr, d0[m0_rr*8 +: 8]);
        end
        m0_rr = (m0_rr + 1) % 4;
      end
    end
    v0 = 4'b0; ack0 = 1'b0;
    last_id = tid0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      ack0 = (i % 2 == 0);
      #1;
      n_cmp++;
      if (tv0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 4'b0 || tid0 !== last_id || err0 !== 1'b0) begin
        n_fail++;
        $display("FAIL t0_idle_ack i%0d: got v=%b busy=%b rdy=%b id=%0d err=%b want 0 0 0000 %0d 0",
                 i, tv0, busy0, rdy0, tid0, err0, last_id);
      end
    end
    @(negedge clk1);
    ack0 = 1'b0; v0 = 4'b0100; d0 = $urandom;
    w = -1;
    for (int k = 0; k < 4; k++) if (w < 0 && v0[(m0_rr + k) % 4]) w = (m0_rr + k) % 4;
    #1;
    n_cmp++; if (rdy0 !== 4'(1 << w)) begin n_fail++; $display("FAIL t0_grant: got %b want %b", rdy0, 4'(1 << w)); end
    @(negedge clk1);
    v0 = 4'b0;
    #1;
    n_cmp++;
    if (tv0 !== 1'b1 || tid0 !== 2'(w) || tdat0 !== d0[w*8 +: 8]) begin
      n_fail++;
      $display("FAIL t0_send: got v=%b id=%0d d=%h want 1 %0d %h", tv0, tid0, tdat0, w, d0[w*8 +: 8]);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap_skip();
    test_ack_on_expiry();
    test_timeout();
    test_reset_mid_send();
    test_random();
    test_turn0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
